// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings driven by the
// control decoder and the default multi-cycle latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit: results computed up front and staged,
// a down-counter models latency and commits them to HI/LO at the end.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDOut
);

    localparam logic [3:0] MCNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DCNT = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        idle;
    logic        div_zero;
    logic        ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvs_u;
    logic [31:0] dvs_s;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;

    assign idle = (cnt_q == 4'd0);
    assign Busy = !idle;

    assign prod_s = $signed({{32{A[31]}}, A})
                  * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Safe divisors keep the simulator clear of /0 and INT_MIN/-1 traps
    assign div_zero = (B == 32'd0);
    assign ovf      = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign dvs_u    = div_zero ? 32'd1 : B;
    assign dvs_s    = ovf ? 32'd1 : dvs_u;

    assign quo_s = ovf ? A     : 32'($signed(A) / $signed(dvs_s));
    assign rem_s = ovf ? 32'd0 : 32'($signed(A) % $signed(dvs_s));
    assign quo_u = A / dvs_u;
    assign rem_u = A % dvs_u;

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        cnt_d    = cnt_q;
        if (idle) begin
            if (Start) begin
                case (MDOp)
                    MD_MULT: begin
                        {tmp_hi_d, tmp_lo_d} = prod_s;
                        cnt_d = MCNT;
                    end
                    MD_MULTU: begin
                        {tmp_hi_d, tmp_lo_d} = prod_u;
                        cnt_d = MCNT;
                    end
                    MD_DIV: begin
                        // HI/LO are frozen while busy, so staging them
                        // makes divide-by-zero a no-op commit
                        tmp_hi_d = div_zero ? hi_q : rem_s;
                        tmp_lo_d = div_zero ? lo_q : quo_s;
                        cnt_d    = DCNT;
                    end
                    MD_DIVU: begin
                        tmp_hi_d = div_zero ? hi_q : rem_u;
                        tmp_lo_d = div_zero ? lo_q : quo_u;
                        cnt_d    = DCNT;
                    end
                    default: ;
                endcase
            end
            if (MDOp == MD_MTHI) hi_d = A;
            if (MDOp == MD_MTLO) lo_d = A;
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = tmp_hi_q;
                lo_d = tmp_lo_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (MDOp == MD_MFHI) MDOut = hi_q;
        else if (MDOp == MD_MFLO) MDOut = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, corner-case sequences and
// random operations checked against an arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic        start = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy;
    logic [31:0] md_out;

    int tests = 0;
    int fails = 0;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .MDOp   (md_op),
        .Start  (start),
        .A      (a_i),
        .B      (b_i),
        .Busy   (busy),
        .MDOut  (md_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b,
            input logic [31:0] hi, input logic [31:0] lo);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] r = {hi, lo};
        case (op)
            4'd1: r = 64'(sa * sb);
            4'd2: r = {32'b0, a} * {32'b0, b};
            4'd3: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            4'd4: if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        md_op = op; start = 1'b1; a_i = a; b_i = b;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 4'd0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        @(negedge clk);
        md_op = MD_MTHI; a_i = hi;
        @(negedge clk);
        md_op = MD_MTLO; a_i = lo;
        @(negedge clk);
        md_op = MD_NONE;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        md_op = MD_MFHI;
        #1 hi = md_out;
        md_op = MD_MFLO;
        #1 lo = md_out;
        md_op = MD_NONE;
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic [31:0] m_hi, m_lo;
        logic [63:0] r;
        int n, m;

        vecs[0] = '{"mult", MD_MULT, 32'hFFFF_FFFE, 32'h3, 0, 0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFA, NM};
        vecs[1] = '{"multu", MD_MULTU, 32'hFFFF_FFFE, 32'h3, 0, 0,
                    32'h2, 32'hFFFF_FFFA, NM};
        vecs[2] = '{"div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, ND};
        vecs[3] = '{"divu_zero", MD_DIVU, 32'h7, 32'h0, 32'h11, 32'h22,
                    32'h11, 32'h22, ND};
        vecs[4] = '{"div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h5, 32'h6, 32'h0, 32'h8000_0000, ND};
        vecs[5] = '{"divu", MD_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, ND};
        vecs[6] = '{"div_negdiv", MD_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0,
                    32'd1, 32'hFFFF_FFFD, ND};

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k <= 8; k++) begin
            md_op = 4'(k);
            #1 check($sformatf("reset_mdout_op%0d", k), md_out, 32'd0);
        end
        md_op = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            count_busy(n);
            check({vecs[i].name, "_busy"}, 32'(n), 32'(vecs[i].cyc));
            read_hilo(hi, lo);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        write_hilo(32'h0, 32'h0);
        @(negedge clk);
        md_op = MD_MTHI; a_i = 32'h1234_5678;
        @(negedge clk);
        md_op = MD_MFHI;
        #1 check("mthi_mfhi", md_out, 32'h1234_5678);
        md_op = MD_MFLO;
        #1 check("mthi_mflo", md_out, 32'h0);
        md_op = MD_NONE;

        // Ignored requests: op without Start, Start with a non-arith op
        @(negedge clk);
        md_op = MD_MULT; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        md_op = MD_MFLO; start = 1'b1;
        @(negedge clk);
        #1 check("ignored_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; md_op = MD_NONE;
        read_hilo(hi, lo);
        check("ignored_hi", hi, 32'h1234_5678);
        check("ignored_lo", lo, 32'h0);

        // Start and mthi while running must not disturb the mult
        issue(MD_MULT, 32'd1000, 32'd3000);
        n = 0;
        @(negedge clk);
        if (busy) n++;
        md_op = MD_DIV; start = 1'b1; a_i = 32'd50; b_i = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_MTHI; a_i = 32'hDEAD_BEEF;
        @(negedge clk);
        if (busy) n++;
        @(posedge clk);
        #1 md_op = MD_NONE;
        count_busy(m);
        check("restart_busy", 32'(n + m), 32'(NM));
        // Back-to-back issue on the very next edge after Busy falls
        md_op = MD_MULTU; start = 1'b1; a_i = 32'd7; b_i = 32'd6;
        @(posedge clk);
        #1 start = 1'b0; md_op = MD_NONE;
        count_busy(n);
        check("b2b_busy", 32'(n), 32'(NM));
        read_hilo(hi, lo);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd42);

        write_hilo(32'hAAAA_AAAA, 32'h5555_5555);
        issue(MD_MULT, 32'd1000, 32'd3000);
        read_hilo(hi, lo);
        check("restart_first_hi", hi, 32'hAAAA_AAAA);
        count_busy(n);
        read_hilo(hi, lo);
        check("restart_res_hi", hi, 32'd0);
        check("restart_res_lo", lo, 32'd3_000_000);

        // Asynchronous reset in busy cycle 3 discards the result
        issue(MD_MULT, 32'hFFFF_FFFE, 32'h3);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_busy_now", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("rst_no_busy", 32'(n), 32'd0);
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] ra, rb;
            op = 4'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 16));
                3: rb = -32'($urandom_range(1, 16));
                default: ;
            endcase
            r = ref_model(op, ra, rb, m_hi, m_lo);
            {m_hi, m_lo} = r;
            issue(op, ra, rb);
            count_busy(n);
            check($sformatf("rand%0d_busy", i), 32'(n),
                  32'((op <= 4'd2) ? NM : ND));
            read_hilo(hi, lo);
            check($sformatf("rand%0d_hi op%0d", i, op), hi, m_hi);
            check($sformatf("rand%0d_lo op%0d", i, op), lo, m_lo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
